// File: rtl/bcd_updown_display_counter.sv
// ============================================================================
// Module   : bcd_updown_display_counter
// Brief    : Multi-digit BCD up/down counter with a multiplexed 7-segment scan
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_updown_display_counter #(
   parameter int NUM_DIGITS = 3,
   parameter int TICK_DIV   = 100_000_000,
   parameter int SCAN_DIV   = 100_000,
   parameter int SATURATE   = 0,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                    i_clk_fpga,
   input  logic                    reset,
   input  logic                    en,
   input  logic                    dir,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_val,
   output logic [4*NUM_DIGITS-1:0] count_bcd,
   output logic [7:0]              seven_seg,
   output logic [NUM_DIGITS-1:0]   seg_en,
   output logic                    led
);

   localparam int c_W  = 4 * NUM_DIGITS;
   localparam int c_TW = $clog2(TICK_DIV);
   localparam int c_SW = $clog2(SCAN_DIV);
   localparam int c_IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(TICK_DIV - 1);
   localparam logic [c_SW-1:0] c_SCAN_LAST = c_SW'(SCAN_DIV - 1);
   localparam logic [c_IW-1:0] c_IDX_LAST  = c_IW'(NUM_DIGITS - 1);
   localparam logic [c_W-1:0]  c_ALL9      = {NUM_DIGITS{4'h9}};
   localparam logic [7:0]      c_SEG_OFF   = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [NUM_DIGITS-1:0] c_EN_OFF =
      (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

   logic [c_TW-1:0]       tdiv_q;
   logic [c_SW-1:0]       sdiv_q;
   logic [c_IW-1:0]       idx_q;
   logic [c_W-1:0]        count_q, count_d;
   logic                  led_q, led_d;
   logic [7:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] segen_q, segen_d;

   logic                  w_tick;
   logic [3:0]            w_digit;
   logic [6:0]            w_seg7;
   logic [NUM_DIGITS-1:0] w_onehot;

   assign w_tick = (tdiv_q == c_TICK_LAST);

   // Ripple carry/borrow across digits; a load always wins over a tick.
   always_comb begin
      logic v_c;
      count_d = count_q;
      v_c     = 1'b1;
      if (load) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            count_d[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
         end
      end else if (w_tick && en) begin
         if (dir) begin
            if (!(SATURATE != 0 && count_q == c_ALL9)) begin
               for (int i = 0; i < NUM_DIGITS; i++) begin
                  if (v_c) begin
                     if (count_q[4*i +: 4] == 4'd9) begin
                        count_d[4*i +: 4] = 4'd0;
                     end else begin
                        count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                        v_c = 1'b0;
                     end
                  end
               end
            end
         end else begin
            if (!(SATURATE != 0 && count_q == '0)) begin
               for (int i = 0; i < NUM_DIGITS; i++) begin
                  if (v_c) begin
                     if (count_q[4*i +: 4] == 4'd0) begin
                        count_d[4*i +: 4] = 4'd9;
                     end else begin
                        count_d[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                        v_c = 1'b0;
                     end
                  end
               end
            end
         end
      end
   end

   assign led_d = dir ? (count_d == c_ALL9) : (count_d == '0);

   always_comb begin
      w_digit  = 4'd0;
      w_onehot = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == c_IW'(i)) begin
            w_digit     = count_q[4*i +: 4];
            w_onehot[i] = 1'b1;
         end
      end
   end

   always_comb begin
      case (w_digit)
         4'd0:    w_seg7 = 7'h3F;
         4'd1:    w_seg7 = 7'h06;
         4'd2:    w_seg7 = 7'h5B;
         4'd3:    w_seg7 = 7'h4F;
         4'd4:    w_seg7 = 7'h66;
         4'd5:    w_seg7 = 7'h6D;
         4'd6:    w_seg7 = 7'h7D;
         4'd7:    w_seg7 = 7'h07;
         4'd8:    w_seg7 = 7'h7F;
         4'd9:    w_seg7 = 7'h6F;
         default: w_seg7 = 7'h00;
      endcase
   end

   // dp is always off, so its active-high value is 0 before polarity is applied.
   assign seg_d   = (ACTIVE_LOW != 0) ? ~{1'b0, w_seg7} : {1'b0, w_seg7};
   assign segen_d = (ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;

   always_ff @(posedge i_clk_fpga or negedge reset) begin
      if (!reset) begin
         tdiv_q  <= '0;
         sdiv_q  <= '0;
         idx_q   <= '0;
         count_q <= '0;
         led_q   <= 1'b0;
         seg_q   <= c_SEG_OFF;
         segen_q <= c_EN_OFF;
      end else begin
         tdiv_q  <= w_tick ? '0 : tdiv_q + 1'b1;
         count_q <= count_d;
         led_q   <= led_d;
         seg_q   <= seg_d;
         segen_q <= segen_d;
         if (sdiv_q == c_SCAN_LAST) begin
            sdiv_q <= '0;
            idx_q  <= (idx_q == c_IDX_LAST) ? '0 : idx_q + 1'b1;
         end else begin
            sdiv_q <= sdiv_q + 1'b1;
         end
      end
   end

   assign count_bcd = count_q;
   assign seven_seg = seg_q;
   assign seg_en    = segen_q;
   assign led       = led_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_updown_display_counter.sv
// ============================================================================
// Module   : tb_bcd_updown_display_counter
// Brief    : Randomised and directed bench; wrap and saturate instances side by side
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bcd_updown_display_counter;

   localparam int ND = 3;
   localparam int TD = 4;
   localparam int SD = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        dir = 1'b1;
   logic        load = 1'b0;
   logic [11:0] load_val = 12'h000;

   logic [11:0] cnt0, cnt1;
   logic [7:0]  ss0, ss1;
   logic [2:0]  se0, se1;
   logic        led0, led1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bcd_updown_display_counter #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD),
                                .SATURATE(0), .ACTIVE_LOW(1)) dut0 (
      .i_clk_fpga(clk), .reset(rst_n), .en(en), .dir(dir), .load(load),
      .load_val(load_val), .count_bcd(cnt0), .seven_seg(ss0), .seg_en(se0), .led(led0));

   bcd_updown_display_counter #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD),
                                .SATURATE(1), .ACTIVE_LOW(1)) dut1 (
      .i_clk_fpga(clk), .reset(rst_n), .en(en), .dir(dir), .load(load),
      .load_val(load_val), .count_bcd(cnt1), .seven_seg(ss1), .seg_en(se1), .led(led1));

   // Reference model: the count is a plain decimal integer 0..999.
   int         m_cyc, m_scyc;
   int         m_v   [2];
   logic       m_led [2];
   logic [7:0] m_ss  [2];
   logic [2:0] m_se;

   function automatic int bcd2int(input logic [11:0] b);
      int r;
      r = 0;
      for (int i = 2; i >= 0; i--) begin
         int d;
         d = int'((b >> (4 * i)) & 12'h00F);
         if (d > 9) d = 9;
         r = r * 10 + d;
      end
      return r;
   endfunction

   function automatic logic [11:0] int2bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [6:0] seg7(input int d);
      case (d)
         0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
         4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
         8: return 7'h7F;  9: return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   function automatic int step(input int v, input int sat);
      if (load) return bcd2int(load_val);
      if ((m_cyc % TD) == TD - 1 && en) begin
         if (dir) return (v == 999) ? (sat != 0 ? 999 : 0) : v + 1;
         else     return (v == 0)   ? (sat != 0 ? 0 : 999) : v - 1;
      end
      return v;
   endfunction

   function automatic int digit_of(input int v, input int idx);
      return (idx == 0) ? v % 10 : (idx == 1) ? (v / 10) % 10 : (v / 100) % 10;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cyc  <= 0;
         m_scyc <= 0;
         m_se   <= 3'b111;
         for (int k = 0; k < 2; k++) begin
            m_v[k]   <= 0;
            m_led[k] <= 1'b0;
            m_ss[k]  <= 8'hFF;
         end
      end else begin
         m_cyc  <= m_cyc + 1;
         m_scyc <= m_scyc + 1;
         m_se   <= ~(3'b001 << ((m_scyc / SD) % ND));
         for (int k = 0; k < 2; k++) begin
            m_v[k]   <= step(m_v[k], k);
            m_led[k] <= dir ? (step(m_v[k], k) == 999) : (step(m_v[k], k) == 0);
            m_ss[k]  <= {1'b1, ~seg7(digit_of(m_v[k], (m_scyc / SD) % ND))};
         end
      end
   end

   task automatic test_reset;
      rst_n = 1'b0;
      @(negedge clk);
      n_vec += 4;
      if (cnt0 !== 12'h000 || cnt1 !== 12'h000) begin
         n_err++; $display("FAIL reset_count: got %h/%h want 000", cnt0, cnt1);
      end
      if (se0 !== 3'b111 || se1 !== 3'b111) begin
         n_err++; $display("FAIL reset_seg_en: got %b/%b want 111", se0, se1);
      end
      if (ss0 !== 8'hFF || ss1 !== 8'hFF) begin
         n_err++; $display("FAIL reset_seven_seg: got %h/%h want FF", ss0, ss1);
      end
      if (led0 !== 1'b0 || led1 !== 1'b0) begin
         n_err++; $display("FAIL reset_led: got %b/%b want 0", led0, led1);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_count_up;
      en = 1'b1; dir = 1'b1;
      for (int c = 1; c <= 48; c++) begin
         @(negedge clk);
         n_vec += 2;
         if (cnt0 !== int2bcd(c / TD)) begin
            n_err++; $display("FAIL count_up cycle %0d: got %h want %h", c, cnt0, int2bcd(c / TD));
         end
         if (led0 !== 1'b0) begin
            n_err++; $display("FAIL count_up_led cycle %0d: got %b want 0", c, led0);
         end
      end
   endtask

   task automatic test_limits(input logic up);
      load = 1'b1; load_val = up ? 12'h998 : 12'h001; dir = up; en = 1'b1;
      @(negedge clk);
      load = 1'b0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         n_vec += 2;
         if (cnt0 !== int2bcd(m_v[0]) || led0 !== m_led[0]) begin
            n_err++; $display("FAIL limits_wrap: got %h led %b want %h led %b",
                              cnt0, led0, int2bcd(m_v[0]), m_led[0]);
         end
         if (cnt1 !== int2bcd(m_v[1]) || led1 !== m_led[1]) begin
            n_err++; $display("FAIL limits_sat: got %h led %b want %h led %b",
                              cnt1, led1, int2bcd(m_v[1]), m_led[1]);
         end
      end
      n_vec++;
      if (cnt1 !== (up ? 12'h999 : 12'h000) || led1 !== 1'b1) begin
         n_err++; $display("FAIL sat_hold dir %b: got %h led %b want %h led 1",
                           up, cnt1, led1, up ? 12'h999 : 12'h000);
      end
   endtask

   task automatic test_load_tick;
      for (int c = 0; c < TD && (m_cyc % TD) != TD - 1; c++) @(negedge clk);
      load = 1'b1; load_val = 12'h5A3; en = 1'b1; dir = 1'b1;
      @(negedge clk);
      load = 1'b0; en = 1'b0;
      n_vec++;
      if (cnt0 !== 12'h593 || cnt1 !== 12'h593) begin
         n_err++; $display("FAIL load_over_tick: got %h/%h want 593", cnt0, cnt1);
      end
      for (int c = 0; c < 3 * TD; c++) begin
         @(negedge clk);
         n_vec++;
         if (cnt0 !== 12'h593 || cnt1 !== 12'h593) begin
            n_err++; $display("FAIL en_freeze: got %h/%h want 593", cnt0, cnt1);
         end
      end
   endtask

   task automatic test_scan;
      logic [7:0] exp_ss;
      load = 1'b1; load_val = 12'h123; en = 1'b0;
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         case (se0)
            3'b110:  exp_ss = ~8'h4F;
            3'b101:  exp_ss = ~8'h5B;
            3'b011:  exp_ss = ~8'h06;
            default: exp_ss = 8'hXX;
         endcase
         n_vec += 2;
         if (ss0 !== exp_ss) begin
            n_err++; $display("FAIL scan_decode: seg_en %b seven_seg %h want %h", se0, ss0, exp_ss);
         end
         if (se0 !== m_se || ss0 !== m_ss[0]) begin
            n_err++; $display("FAIL scan_order: got %b/%h want %b/%h", se0, ss0, m_se, m_ss[0]);
         end
      end
   endtask

   task automatic test_random;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         n_vec += 3;
         if (cnt0 !== int2bcd(m_v[0]) || cnt1 !== int2bcd(m_v[1])) begin
            n_err++; $display("FAIL rand_count: got %h/%h want %h/%h",
                              cnt0, cnt1, int2bcd(m_v[0]), int2bcd(m_v[1]));
         end
         if (led0 !== m_led[0] || led1 !== m_led[1]) begin
            n_err++; $display("FAIL rand_led: got %b/%b want %b/%b", led0, led1, m_led[0], m_led[1]);
         end
         if (se0 !== m_se || ss0 !== m_ss[0] || se1 !== m_se || ss1 !== m_ss[1]) begin
            n_err++; $display("FAIL rand_display: got %b/%h %b/%h want %b/%h %b/%h",
                              se0, ss0, se1, ss1, m_se, m_ss[0], m_se, m_ss[1]);
         end
         load = ($urandom_range(0, 11) == 0);
         case ($urandom_range(0, 3))
            0:       load_val = 12'h999;
            1:       load_val = 12'h000;
            default: load_val = 12'($urandom);
         endcase
         en  = ($urandom_range(0, 3) != 0);
         dir = 1'($urandom);
      end
      load = 1'b0;
   endtask

   task automatic test_async_reset;
      load = 1'b1; load_val = 12'h047; en = 1'b1; dir = 1'b1;
      @(negedge clk);
      load = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if (cnt0 !== 12'h000 || cnt1 !== 12'h000 || se0 !== 3'b111 || ss0 !== 8'hFF ||
          led0 !== 1'b0 || led1 !== 1'b0) begin
         n_err++; $display("FAIL async_reset: got %h/%h %b %h led %b/%b want 000 111 FF 0",
                           cnt0, cnt1, se0, ss0, led0, led1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         n_vec++;
         if (cnt0 !== int2bcd(c / TD)) begin
            n_err++; $display("FAIL first_tick cycle %0d: got %h want %h", c, cnt0, int2bcd(c / TD));
         end
      end
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_limits(1'b1);
      test_limits(1'b0);
      test_load_tick();
      test_scan();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
